// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int AW_DEF = 32;
    localparam int DW_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

endpackage

// File: rtl/arb_pick.sv
// Winner selection between fetch and data ports.
// MEM_ARB_RR_EN selects round-robin on ties; otherwise the data port always wins.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic   iReq,
    input  logic   dReq,
    input  owner_e lastOwner,
    output owner_e winner
);

    always_comb begin
        winner = lastOwner;
        if (iReq && dReq) begin
`ifdef MEM_ARB_RR_EN
            winner = (lastOwner == OWN_D) ? OWN_I : OWN_D;
`else
            winner = OWN_D;
`endif
        end else if (dReq) begin
            winner = OWN_D;
        end else if (iReq) begin
            winner = OWN_I;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single-cycle-latency memory.
// MEM_ARB_RR_EN: round-robin tie-break; undefined: fixed data-port priority.
//
// state | meaning
// IDLE  | no access in flight, waiting for a request
// ISSUE | memEn and owner's gnt asserted from the latched request
// WAIT  | memRdata returned to owner with rvalid; re-arbitrate
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            iReq,
    input  logic [AW-1:0]   iAddr,
    output logic            iGnt,
    output logic            iRvalid,
    output logic [DW-1:0]   iRdata,
    input  logic            dReq,
    input  logic            dWe,
    input  logic [DW/8-1:0] dBe,
    input  logic [AW-1:0]   dAddr,
    input  logic [DW-1:0]   dWdata,
    output logic            dGnt,
    output logic            dRvalid,
    output logic [DW-1:0]   dRdata,
    output logic            memEn,
    output logic            memWe,
    output logic [DW/8-1:0] memBe,
    output logic [AW-1:0]   memAddr,
    output logic [DW-1:0]   memWdata,
    input  logic [DW-1:0]   memRdata
);

    localparam logic [AW-1:0] OFS_MASK = AW'(DW/8 - 1);

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    owner_e            last_owner, winner;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic [DW/8-1:0]   be_q, be_d;
    logic              we_q, we_d;
    logic              any_req;

`ifdef MEM_ARB_RR_EN
    assign last_owner = owner_q;  // owner of the latest access doubles as last-owner
`else
    assign last_owner = OWN_I;
`endif

    arb_pick u_pick (
        .iReq      (iReq),
        .dReq      (dReq),
        .lastOwner (last_owner),
        .winner    (winner)
    );

    assign any_req = iReq | dReq;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        we_d    = we_q;
        case (state_q)
            ISSUE:   state_d = WAIT;
            IDLE,
            WAIT:    state_d = any_req ? ISSUE : IDLE;
            default: state_d = IDLE;
        endcase
        if ((state_q == IDLE || state_q == WAIT) && any_req) begin
            owner_d = winner;
            if (winner == OWN_D) begin
                addr_d  = dAddr;
                we_d    = dWe;
                be_d    = dWe ? dBe : '1;
                wdata_d = dWe ? dWdata : '0;
            end else begin
                addr_d  = iAddr;
                we_d    = 1'b0;
                be_d    = '1;
                wdata_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= OWN_I;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            we_q    <= we_d;
        end
    end

    assign memEn    = (state_q == ISSUE);
    assign memWe    = memEn && we_q && (|be_q);
    assign memBe    = be_q;
    assign memAddr  = addr_q & ~OFS_MASK;
    assign memWdata = wdata_q;

    assign iGnt     = memEn && (owner_q == OWN_I);
    assign dGnt     = memEn && (owner_q == OWN_D);
    assign iRvalid  = (state_q == WAIT) && (owner_q == OWN_I);
    assign dRvalid  = (state_q == WAIT) && (owner_q == OWN_D);
    assign iRdata   = iRvalid ? memRdata : '0;
    // stores complete with zero data
    assign dRdata   = (dRvalid && !we_q) ? memRdata : '0;

endmodule
